btn_pulser: RTL

Front-end event source for the stopwatch control FSM. Takes the two raw, bouncing, asynchronous push-button inputs (start/stop and split/clear) and produces the clean single-cycle `trig` and `split` pulses that the control block consumes. Sits between the board pins and the control FSM, in the `clk` domain. It is the producing end of the `trig`/`split` event interface.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/btn_pulser_if.sv | 10 +
 rtl/btn_debounce.sv | 88 ++++++++
 rtl/btn_pulser.sv | 56 +++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: debounce FSM states, event payload and debounce defaults.
package stopwatch_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF   = 4;
   // 10 ms at 100 MHz for the board build
   localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1_000_000;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   typedef struct packed {
      logic trig;
      logic split;
   } btn_evt_t;

endpackage

// File: rtl/btn_pulser_if.sv
// trig/split event interface between the button front end and the control FSM.
interface btn_pulser_if;

   logic trig;
   logic split;

   modport master (output trig, output split);
   modport slave  (input  trig, input  split);

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and stability counter.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic            q1_q, q1_d;
   logic            q2_q, q2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   db_state_t       state_q, state_d;

   // State register, synchronizer and counter flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q1_q    <= 1'b0;
         q2_q    <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
      end else begin
         q1_q    <= q1_d;
         q2_q    <= q2_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      q1_d    = btn_raw;
      q2_d    = q1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (q2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!q2_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!q2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (q2_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Accept strobe; the pulse register lives in btn_pulser
   always_comb begin
      press_pulse = 1'b0;
      if ((state_q == PRESS_WAIT) && q2_q && (cnt_q == CNT_LAST)) begin
         press_pulse = 1'b1;
      end
   end

endmodule

// File: rtl/btn_pulser.sv
// Two debounced button channels feeding registered one-cycle trig/split pulses.
// Optional BTN_MUTEX_EN: trig wins when both channels accept on the same edge.
module btn_pulser
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btn_trig_raw,
   input  logic            btn_split_raw,
   btn_pulser_if.master    evt
);

   logic     trig_acc;
   logic     split_acc;
   btn_evt_t evt_q, evt_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_trig (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_trig_raw),
      .press_pulse (trig_acc)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_split (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_split_raw),
      .press_pulse (split_acc)
   );

   // Pulse selection; a suppressed split press is dropped, not deferred
   always_comb begin
      evt_d.trig  = trig_acc;
      evt_d.split = split_acc;
`ifdef BTN_MUTEX_EN
      if (trig_acc) begin
         evt_d.split = 1'b0;
      end
`endif
   end

   // Output pulse registers, cleared on every edge they are not set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_d;
      end
   end

   assign evt.trig  = evt_q.trig;
   assign evt.split = evt_q.split;

endmodule
